// File: rtl/nvdla_cdp_wdma_fifo_pkg.sv
// Shared helpers for the CDP WDMA command FIFO: parameter legality,
// occupancy counter width and pointer wrap arithmetic.
package nvdla_cdp_wdma_fifo_pkg;

    localparam int PTR_MAX_W = 7;

    function automatic bit params_ok(input int width, input int depth, input int afull_lvl);
        return (width >= 1) && (width <= 256) &&
               (depth >= 2) && (depth <= 64) &&
               (afull_lvl >= 1) && (afull_lvl <= depth);
    endfunction

    // Occupancy runs 0..depth inclusive, hence depth+1 codes.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                     input int depth);
        if (int'(ptr) >= depth - 1) begin
            return '0;
        end
        return ptr + PTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/nvdla_cdp_wdma_fifo_flopram.sv
// Flop-based storage array: one synchronous write port, one asynchronous
// read port, no reset on the contents.
module nvdla_cdp_wdma_fifo_flopram #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wa,
    input  logic [WIDTH-1:0] i_di,
    input  logic [AW-1:0]    i_ra,
    output logic [WIDTH-1:0] o_dout,
    input  logic [31:0]      i_pwrbus_ram_pd
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Power control has no effect on a flop array; kept for RAM-compatible wiring.
    logic w_unused_pwrbus;

    assign w_unused_pwrbus = ^i_pwrbus_ram_pd;
    assign o_dout          = r_mem[i_ra];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_di;
        end
    end

endmodule

// File: rtl/nvdla_cdp_wdma_cmd_fifo_gen.sv
// CDP WDMA command FIFO: registered output stage plus flop RAM, with bypass
// into the output register when the RAM holds nothing.
module nvdla_cdp_wdma_cmd_fifo_gen
    import nvdla_cdp_wdma_fifo_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter int DEPTH     = 3,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                          nvdla_core_clk_mgated,
    input  logic                          nvdla_core_rstn,
    input  logic                          wr_pvld,
    output logic                          wr_prdy,
    input  logic [WIDTH-1:0]              wr_pd,
    output logic                          rd_pvld,
    input  logic                          rd_prdy,
    output logic [WIDTH-1:0]              rd_pd,
    input  logic                          flush,
    output logic [cnt_width(DEPTH)-1:0]   wr_count,
    output logic                          wr_afull,
    output logic                          clk_en,
    input  logic [31:0]                   pwrbus_ram_pd
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    if (!params_ok(WIDTH, DEPTH, AFULL_LVL)) begin : g_param_check
        $error("nvdla_cdp_wdma_cmd_fifo_gen: illegal WIDTH/DEPTH/AFULL_LVL");
    end

    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_busy;
    logic             r_rd_pvld;
    logic             r_afull;
    logic [WIDTH-1:0] r_rd_pd;

    logic             w_push;
    logic             w_pop;
    logic             w_ram_empty;
    logic             w_out_free;
    logic             w_load;
    logic             w_bypass;
    logic             w_ram_we;
    logic [CW-1:0]    w_next_count;
    logic             w_busy_next;
    logic             w_afull_next;
    logic [PW-1:0]    w_wr_ptr_inc;
    logic [PW-1:0]    w_rd_ptr_inc;
    logic [WIDTH-1:0] w_ram_rd;

    assign wr_prdy = !r_busy && !flush;
    assign w_push  = wr_pvld && wr_prdy;
    assign w_pop   = r_rd_pvld && rd_prdy;

    // RAM holds everything except the entry sitting in the output register.
    assign w_ram_empty = (r_count == CW'(r_rd_pvld));
    assign w_out_free  = !r_rd_pvld || w_pop;
    assign w_load      = w_out_free && !w_ram_empty;
    assign w_bypass    = w_push && w_out_free && w_ram_empty;
    assign w_ram_we    = w_push && !w_bypass;

    assign w_next_count = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_busy_next = r_busy;
        if (flush || w_pop) begin
            w_busy_next = 1'b0;
        end else if (w_next_count == CW'(DEPTH)) begin
            w_busy_next = 1'b1;
        end
    end

    assign w_afull_next = !flush && (w_next_count >= CW'(AFULL_LVL));

    assign w_wr_ptr_inc = PW'(ptr_inc(PTR_MAX_W'(r_wr_ptr), DEPTH));
    assign w_rd_ptr_inc = PW'(ptr_inc(PTR_MAX_W'(r_rd_ptr), DEPTH));

    assign clk_en = wr_pvld || w_pop || flush ||
                    ((r_count != '0) && !r_rd_pvld) ||
                    (w_busy_next != r_busy);

    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_busy    <= 1'b0;
            r_rd_pvld <= 1'b0;
            r_afull   <= 1'b0;
        end else begin
            r_busy  <= w_busy_next;
            r_afull <= w_afull_next;
            if (flush) begin
                r_count   <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_rd_pvld <= 1'b0;
            end else begin
                r_count <= w_next_count;
                if (w_ram_we) begin
                    r_wr_ptr <= w_wr_ptr_inc;
                end
                if (w_load) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
                if (w_out_free) begin
                    r_rd_pvld <= w_load || w_bypass;
                end
            end
        end
    end

    // Output payload is deliberately unreset; flush leaves it untouched.
    always_ff @(posedge nvdla_core_clk_mgated) begin
        if (!flush && w_load) begin
            r_rd_pd <= w_ram_rd;
        end else if (!flush && w_bypass) begin
            r_rd_pd <= wr_pd;
        end
    end

    nvdla_cdp_wdma_fifo_flopram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk           (nvdla_core_clk_mgated),
        .i_we            (w_ram_we),
        .i_wa            (r_wr_ptr),
        .i_di            (wr_pd),
        .i_ra            (r_rd_ptr),
        .o_dout          (w_ram_rd),
        .i_pwrbus_ram_pd (pwrbus_ram_pd)
    );

    assign rd_pvld  = r_rd_pvld;
    assign rd_pd    = r_rd_pd;
    assign wr_count = r_count;
    assign wr_afull = r_afull;

endmodule

// File: tb/tb_nvdla_cdp_wdma_cmd_fifo_gen.sv
// Bench for the CDP WDMA command FIFO: a 3-deep and a 5-deep instance share
// inputs; each is checked against a queue model, plus directed vector tables.
module tb_nvdla_cdp_wdma_cmd_fifo_gen;

    localparam int W   = 15;
    localparam int D3  = 3;
    localparam int AF3 = 2;
    localparam int D5  = 5;
    localparam int AF5 = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         wr_pvld;
    logic         rd_prdy;
    logic         flush;
    logic [W-1:0] wr_pd;
    logic [31:0]  pwrbus;

    logic         prdy3, pvld3, afull3, clken3;
    logic [W-1:0] pd3;
    logic [1:0]   cnt3;
    logic         prdy5, pvld5, afull5, clken5;
    logic [W-1:0] pd5;
    logic [2:0]   cnt5;

    // Valid/ready: a transfer happens at a rising edge where valid and ready are both high.
    always #5 clk = ~clk;

    nvdla_cdp_wdma_cmd_fifo_gen #(.WIDTH(W), .DEPTH(D3)) u_dut3 (
        .nvdla_core_clk_mgated (clk),
        .nvdla_core_rstn       (rstn),
        .wr_pvld               (wr_pvld),
        .wr_prdy               (prdy3),
        .wr_pd                 (wr_pd),
        .rd_pvld               (pvld3),
        .rd_prdy               (rd_prdy),
        .rd_pd                 (pd3),
        .flush                 (flush),
        .wr_count              (cnt3),
        .wr_afull              (afull3),
        .clk_en                (clken3),
        .pwrbus_ram_pd         (pwrbus)
    );

    nvdla_cdp_wdma_cmd_fifo_gen #(.WIDTH(W), .DEPTH(D5)) u_dut5 (
        .nvdla_core_clk_mgated (clk),
        .nvdla_core_rstn       (rstn),
        .wr_pvld               (wr_pvld),
        .wr_prdy               (prdy5),
        .wr_pd                 (wr_pd),
        .rd_pvld               (pvld5),
        .rd_prdy               (rd_prdy),
        .rd_pd                 (pd5),
        .flush                 (flush),
        .wr_count              (cnt5),
        .wr_afull              (afull5),
        .clk_en                (clken5),
        .pwrbus_ram_pd         (pwrbus)
    );

    logic [W-1:0] exp_q3[$];
    logic [W-1:0] exp_q5[$];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         wv;
        logic [W-1:0] pd;
        logic         rp;
        logic         fl;
        logic         e_pvld;
        logic [W-1:0] e_pd;
        int           e_cnt;
        logic         e_prdy;
        logic         e_afull;
        logic         e_clken;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input bit wv, input int pd, input bit rp, input bit fl,
                                input bit ep, input int epd, input int ec,
                                input bit epr, input bit eaf, input bit ece);
        vec_t v;
        v.wv = wv; v.pd = W'(pd); v.rp = rp; v.fl = fl;
        v.e_pvld = ep; v.e_pd = W'(epd); v.e_cnt = ec;
        v.e_prdy = epr; v.e_afull = eaf; v.e_clken = ece;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs follow from queue occupancy alone: head of queue is the
    // output, ready means not full, clk_en wakes on any request or full-flag change.
    task automatic model_check(input string tag, input int d, input int af,
                               input int size, input logic [W-1:0] head,
                               input logic a_pvld, input logic [W-1:0] a_pd,
                               input int a_cnt, input logic a_prdy,
                               input logic a_afull, input logic a_clken);
        bit popx, pushx;
        int nsize;
        popx  = (size > 0) && rd_prdy;
        pushx = wr_pvld && (size < d) && !flush;
        nsize = flush ? 0 : size + int'(pushx) - int'(popx);
        chk({tag, ".rd_pvld"}, a_pvld, size > 0);
        if (size > 0) chk({tag, ".rd_pd"}, a_pd, head);
        chk({tag, ".wr_count"}, a_cnt, size);
        chk({tag, ".wr_prdy"}, a_prdy, (size < d) && !flush);
        chk({tag, ".wr_afull"}, a_afull, size >= af);
        chk({tag, ".clk_en"}, a_clken,
            wr_pvld || popx || flush || ((size == d) != (nsize == d)));
    endtask

    task automatic model_step();
        bit pop3, push3, pop5, push5;
        pop3  = (exp_q3.size() > 0) && rd_prdy;
        push3 = wr_pvld && (exp_q3.size() < D3);
        pop5  = (exp_q5.size() > 0) && rd_prdy;
        push5 = wr_pvld && (exp_q5.size() < D5);
        if (flush) begin
            exp_q3.delete();
            exp_q5.delete();
        end else begin
            if (pop3)  void'(exp_q3.pop_front());
            if (push3) exp_q3.push_back(wr_pd);
            if (pop5)  void'(exp_q5.pop_front());
            if (push5) exp_q5.push_back(wr_pd);
        end
    endtask

    task automatic drive(input logic wv, input logic [W-1:0] pd, input logic rp, input logic fl);
        @(negedge clk);
        wr_pvld = wv; wr_pd = pd; rd_prdy = rp; flush = fl;
        #1;
        model_check("d3", D3, AF3, exp_q3.size(), exp_q3.size() > 0 ? exp_q3[0] : '0,
                    pvld3, pd3, int'(cnt3), prdy3, afull3, clken3);
        model_check("d5", D5, AF5, exp_q5.size(), exp_q5.size() > 0 ? exp_q5[0] : '0,
                    pvld5, pd5, int'(cnt5), prdy5, afull5, clken5);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".d3.rd_pvld"}, pvld3, 1'b0);
        chk({tag, ".d3.wr_count"}, cnt3, 2'd0);
        chk({tag, ".d3.wr_prdy"}, prdy3, 1'b1);
        chk({tag, ".d3.wr_afull"}, afull3, 1'b0);
        chk({tag, ".d5.rd_pvld"}, pvld5, 1'b0);
        chk({tag, ".d5.wr_count"}, cnt5, 3'd0);
    endtask

    initial begin
        // Columns: wr_pvld, wr_pd, rd_prdy, flush | rd_pvld, rd_pd, wr_count, wr_prdy, wr_afull, clk_en
        tbl[0]  = mk(0, 'h0000, 0, 0,  0, 'h0000, 0, 1, 0, 0);
        tbl[1]  = mk(1, 'h1234, 0, 0,  0, 'h0000, 0, 1, 0, 1);
        tbl[2]  = mk(0, 'h0000, 0, 0,  1, 'h1234, 1, 1, 0, 0);
        tbl[3]  = mk(1, 'h0222, 0, 0,  1, 'h1234, 1, 1, 0, 1);
        tbl[4]  = mk(1, 'h0333, 0, 0,  1, 'h1234, 2, 1, 1, 1);
        tbl[5]  = mk(1, 'h0444, 0, 0,  1, 'h1234, 3, 0, 1, 1);
        tbl[6]  = mk(0, 'h0000, 1, 0,  1, 'h1234, 3, 0, 1, 1);
        tbl[7]  = mk(0, 'h0000, 1, 0,  1, 'h0222, 2, 1, 1, 1);
        tbl[8]  = mk(0, 'h0000, 1, 0,  1, 'h0333, 1, 1, 0, 1);
        tbl[9]  = mk(0, 'h0000, 1, 0,  0, 'h0000, 0, 1, 0, 0);
        tbl[10] = mk(1, 'h0aaa, 0, 0,  0, 'h0000, 0, 1, 0, 1);
        tbl[11] = mk(1, 'h0bbb, 0, 0,  1, 'h0aaa, 1, 1, 0, 1);
        tbl[12] = mk(1, 'h0ccc, 0, 1,  1, 'h0aaa, 2, 0, 1, 1);
        tbl[13] = mk(0, 'h0000, 1, 0,  0, 'h0000, 0, 1, 0, 0);
        tbl[14] = mk(1, 'h0ddd, 1, 0,  0, 'h0000, 0, 1, 0, 1);
        tbl[15] = mk(0, 'h0000, 1, 0,  1, 'h0ddd, 1, 1, 0, 1);
        tbl[16] = mk(0, 'h0000, 0, 0,  0, 'h0000, 0, 1, 0, 0);

        // Clock/reset
        rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; flush = 1'b0; wr_pd = '0; pwrbus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Directed table on the 3-deep instance
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].wv, tbl[i].pd, tbl[i].rp, tbl[i].fl);
            chk($sformatf("tbl%0d.rd_pvld", i), pvld3, tbl[i].e_pvld);
            if (tbl[i].e_pvld) chk($sformatf("tbl%0d.rd_pd", i), pd3, tbl[i].e_pd);
            chk($sformatf("tbl%0d.wr_count", i), cnt3, tbl[i].e_cnt);
            chk($sformatf("tbl%0d.wr_prdy", i), prdy3, tbl[i].e_prdy);
            chk($sformatf("tbl%0d.wr_afull", i), afull3, tbl[i].e_afull);
            chk($sformatf("tbl%0d.clk_en", i), clken3, tbl[i].e_clken);
            step();
        end

        // Streaming on the 5-deep instance: two preloaded entries, then push+pop each cycle
        drive(1'b1, W'('h100), 1'b0, 1'b0); step();
        drive(1'b1, W'('h101), 1'b0, 1'b0); step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, W'('h102 + i), 1'b1, 1'b0);
            chk($sformatf("stream%0d.rd_pvld", i), pvld5, 1'b1);
            chk($sformatf("stream%0d.rd_pd", i), pd5, W'('h100 + i));
            chk($sformatf("stream%0d.wr_count", i), cnt5, 3'd2);
            step();
        end
        repeat (3) begin
            drive(1'b0, '0, 1'b1, 1'b0); step();
        end

        // Reset in the middle of operation
        drive(1'b1, W'('h555), 1'b0, 1'b0); step();
        drive(1'b1, W'('h666), 1'b0, 1'b0); step();
        @(negedge clk);
        wr_pvld = 1'b0; rd_prdy = 1'b0; flush = 1'b0;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q3.delete();
        exp_q5.delete();
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, W'('h777), 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("after_reset.rd_pvld", pvld3, 1'b1);
        chk("after_reset.rd_pd", pd3, W'('h777));
        chk("after_reset.wr_count", cnt3, 2'd1);
        step();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, W'($urandom_range(0, 32767)),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
